// File: rtl/pc_fetch_control_if.sv
// Fetch-stage bus: hazard/debug control inputs, instruction-memory read
// data, and the PC / IF/ID / halt status outputs of pc_fetch_control.
interface pc_fetch_control_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   i_enable;
    logic                   i_not_load;
    logic                   i_halt;
    logic                   i_jump;
    logic [PC_WIDTH-1:0]    i_jump_addr;
    logic [INSTR_WIDTH-1:0] i_instruction;
    logic [PC_WIDTH-1:0]    o_pc;
    logic [INSTR_WIDTH-1:0] o_if_id_instr;
    logic [PC_WIDTH-1:0]    o_if_id_pc_next;
    logic                   o_halted;
    logic                   o_draining;

    // The fetch block itself.
    modport slave (
        input  i_enable, i_not_load, i_halt, i_jump, i_jump_addr, i_instruction,
        output o_pc, o_if_id_instr, o_if_id_pc_next, o_halted, o_draining
    );

    // The surrounding core / debug unit / instruction memory.
    modport master (
        output i_enable, i_not_load, i_halt, i_jump, i_jump_addr, i_instruction,
        input  o_pc, o_if_id_instr, o_if_id_pc_next, o_halted, o_draining
    );
endinterface

// File: rtl/pc_fetch_control.sv
// Fetch stage: owns the PC and the IF/ID register. Handles stalls from the
// hazard unit, jump redirects with a wrong-path flush, and a drain/halt
// sequence so older instructions retire before halted is reported.
module pc_fetch_control #(
    parameter int PC_WIDTH     = 32,
    parameter int INSTR_WIDTH  = 32,
    parameter int PC_STEP      = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    pc_fetch_control_if.slave      bus
);

    // Wide enough to hold DRAIN_CYCLES-1 even when DRAIN_CYCLES is 1.
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_W-1:0]    DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_next_q;
    logic [PC_WIDTH-1:0]    pc_plus_step;

    // Sequential successor of the current fetch address; wraps modulo 2^PC_WIDTH.
    assign pc_plus_step = pc_q + STEP;

    // PC, IF/ID register and drain/halt FSM; reset wins over enable.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            pc_next_q <= '0;
        end else if (bus.i_enable) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.i_halt) begin
                        // PC and pc_next hold; the HALT itself is replaced by a NOP.
                        instr_q <= '0;
                        cnt_q   <= DRAIN_INIT;
                        state_q <= ST_DRAIN;
                    end else if (bus.i_not_load) begin
                        // Stall: PC and IF/ID hold; a concurrent jump is dropped.
                    end else if (bus.i_jump) begin
                        pc_q      <= bus.i_jump_addr;
                        instr_q   <= '0;
                        pc_next_q <= pc_plus_step;
                    end else begin
                        pc_q      <= pc_plus_step;
                        instr_q   <= bus.i_instruction;
                        pc_next_q <= pc_plus_step;
                    end
                end
                ST_DRAIN: begin
                    instr_q <= '0;
                    if (cnt_q == '0) begin
                        state_q <= ST_HALTED;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    instr_q <= '0;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.o_pc            = pc_q;
    assign bus.o_if_id_instr   = instr_q;
    assign bus.o_if_id_pc_next = pc_next_q;
    assign bus.o_halted        = (state_q == ST_HALTED);
    assign bus.o_draining      = (state_q == ST_DRAIN);

endmodule
